// File: rtl/axis_checker_pkg.sv
// Shared definitions for the stream checker: FSM encoding and LFSR constants.
package axis_checker_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_feedback(input logic [15:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/axis_checker_if.sv
// Valid/ready stream bundle between a counter source and the checker sink.
interface axis_checker_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] idata;
  logic             ivalid;
  logic             iready;

  modport master (output idata, output ivalid, input iready);
  modport slave  (input idata, input ivalid, output iready);
endinterface

// File: rtl/axis_lfsr_ready.sv
// Free-running 16-bit Fibonacci LFSR; bit 0 is offered as a pseudo-random ready.
module axis_lfsr_ready
  import axis_checker_pkg::*;
(
  input  logic clock,
  input  logic reset,
  output logic o_bit
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], lfsr_feedback(r_lfsr)};
    end
  end

  assign o_bit = r_lfsr[0];

endmodule

// File: rtl/axis_checker.sv
// Incrementing-counter stream sink: locks onto the sequence, counts beats and
// mismatches, and throttles ready to stress upstream backpressure.
//
// state  | meaning
// SEARCH | waiting for LOCK_COUNT consecutive correct increments
// LOCKED | sequence tracked; a mismatch counts an error and drops back to SEARCH
module axis_checker
  import axis_checker_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 16,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   throttle,
  axis_checker_if.slave          s_axis,
  output logic                   locked,
  output logic [COUNT_WIDTH-1:0] beats,
  output logic [COUNT_WIDTH-1:0] errors
);

  localparam int                     RUN_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0]       RUN_LOCK = RUN_W'(LOCK_COUNT);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;

  chk_state_e             r_state;
  chk_state_e             w_state_nxt;
  logic [RUN_W-1:0]       r_run;
  logic [RUN_W-1:0]       w_run_nxt;
  logic                   r_have_prev;
  logic                   w_have_nxt;
  logic                   w_err_inc;
  logic                   r_iready;
  logic [WIDTH-1:0]       r_expected;
  logic [COUNT_WIDTH-1:0] r_beats;
  logic [COUNT_WIDTH-1:0] r_errors;
  logic                   w_lfsr_bit;
  logic                   w_xfer;
  logic                   w_match;

  axis_lfsr_ready u_lfsr (
    .clock (clock),
    .reset (reset),
    .o_bit (w_lfsr_bit)
  );

  assign w_xfer  = s_axis.ivalid & r_iready;
  assign w_match = (s_axis.idata == r_expected);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= SEARCH;
      r_run       <= '0;
      r_have_prev <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_run       <= w_run_nxt;
      r_have_prev <= w_have_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_have_nxt  = r_have_prev;
    w_err_inc   = 1'b0;
    if (clear) begin
      w_state_nxt = SEARCH;
      w_run_nxt   = '0;
      w_have_nxt  = 1'b0;
    end else if (w_xfer) begin
      w_have_nxt = 1'b1;
      case (r_state)
        SEARCH: begin
          if (r_have_prev && w_match) begin
            w_run_nxt = r_run + 1'b1;
            if (w_run_nxt == RUN_LOCK) w_state_nxt = LOCKED;
          end else begin
            w_run_nxt = '0;
          end
        end
        LOCKED: begin
          // The mismatching beat itself becomes the first beat of a new run.
          if (!w_match) begin
            w_err_inc   = 1'b1;
            w_state_nxt = SEARCH;
            w_run_nxt   = '0;
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_iready <= 1'b0;
      r_beats  <= '0;
      r_errors <= '0;
    end else begin
      r_iready <= throttle ? w_lfsr_bit : 1'b1;
      if (clear) begin
        r_beats  <= '0;
        r_errors <= '0;
      end else begin
        if (w_xfer && (r_beats != CNT_MAX)) r_beats <= r_beats + 1'b1;
        if (w_err_inc && (r_errors != CNT_MAX)) r_errors <= r_errors + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_xfer) r_expected <= s_axis.idata + 1'b1;
  end

  assign s_axis.iready = r_iready;
  assign locked        = (r_state == LOCKED);
  assign beats         = r_beats;
  assign errors        = r_errors;

endmodule
